// File: rtl/bus_addr_router.sv
// Table-driven single-master / N-slave address router for the SoC data bus.
// Tracks one outstanding transaction and answers unmapped or timed-out requests with an error.
module bus_addr_router #(
    parameter int unsigned NUM_SLAVES     = 9,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] END_ADDRS  = '0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_req,
    output logic                             m_gnt,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic                             m_we,
    input  logic [DATA_WIDTH/8-1:0]          m_be,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    output logic                             m_rvalid,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic [NUM_SLAVES-1:0]            s_req,
    input  logic [NUM_SLAVES-1:0]            s_gnt,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic                             s_we,
    output logic [DATA_WIDTH/8-1:0]          s_be,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]            s_rvalid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    output logic [7:0]                       err_count,
    output logic [ADDR_WIDTH-1:0]            last_err_addr
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        ERR_RSP  = 2'd2
    } state_t;

    state_t                  state;
    logic [SEL_W-1:0]        sel_q;
    logic [CNT_W-1:0]        tmo_cnt;
    logic [CNT_W:0]          cnt_inc;
    logic [ADDR_WIDTH-1:0]   req_addr;

    logic                    hit;
    logic [SEL_W-1:0]        hit_sel;
    logic [ADDR_WIDTH-1:0]   hit_base;
    logic [DATA_WIDTH-1:0]   rdata_arr [NUM_SLAVES];

    // Region decode; scanning downward lets the lowest matching index win overlaps.
    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_base = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((m_addr >= BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (m_addr <= END_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit      = 1'b1;
                hit_sel  = SEL_W'(i);
                hit_base = BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            rdata_arr[i] = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign s_addr  = m_addr - hit_base;
    assign s_we    = m_we;
    assign s_be    = m_be;
    assign s_wdata = m_wdata;
    assign cnt_inc = {1'b0, tmo_cnt} + (CNT_W+1)'(1);

    // Request and response paths are combinational; everything is silenced while in reset.
    always_comb begin
        s_req    = '0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_err    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        s_req[hit_sel] = m_req;
                        m_gnt          = s_gnt[hit_sel];
                    end else begin
                        m_gnt = m_req;
                    end
                end
                WAIT_RSP: begin
                    m_rvalid = s_rvalid[sel_q];
                    m_rdata  = rdata_arr[sel_q];
                end
                ERR_RSP: begin
                    m_rvalid = 1'b1;
                    m_err    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Transaction tracking, timeout and error statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sel_q         <= '0;
            tmo_cnt       <= '0;
            req_addr      <= '0;
            err_count     <= '0;
            last_err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req && m_gnt) begin
                        req_addr <= m_addr;
                        if (hit) begin
                            sel_q   <= hit_sel;
                            tmo_cnt <= '0;
                            state   <= WAIT_RSP;
                        end else begin
                            state <= ERR_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    tmo_cnt <= cnt_inc[CNT_W-1:0];
                    // A response arriving on the final allowed cycle beats the timeout.
                    if (s_rvalid[sel_q]) begin
                        state <= IDLE;
                    end else if (cnt_inc >= (CNT_W+1)'(TIMEOUT_CYCLES)) begin
                        state <= ERR_RSP;
                    end
                end
                ERR_RSP: begin
                    state         <= IDLE;
                    last_err_addr <= req_addr;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_addr_router.sv
// Directed self-checking bench for bus_addr_router: decode, responses, timeout, stats, reset.
module tb_bus_addr_router;

    localparam int unsigned NS  = 9;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned TMO = 4;

    // Slave 2 and 3 overlap in 0x0100_0800..0x0100_0FFF.
    localparam logic [NS*AW-1:0] BASES = {
        32'h0100_5000, 32'h0100_4000, 32'h0100_3000, 32'h0100_2000, 32'h0100_1000,
        32'h0100_0800, 32'h0100_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] ENDS = {
        32'h0100_5FFF, 32'h0100_4FFF, 32'h0100_3FFF, 32'h0100_2FFF, 32'h0100_1FFF,
        32'h0100_0FFF, 32'h0100_0FFF, 32'h0001_FFFF, 32'h0000_0FFF};

    logic             clk = 1'b0;
    logic             rst;
    logic             m_req;
    logic             m_gnt;
    logic [AW-1:0]    m_addr;
    logic             m_we;
    logic [BW-1:0]    m_be;
    logic [DW-1:0]    m_wdata;
    logic             m_rvalid;
    logic [DW-1:0]    m_rdata;
    logic             m_err;
    logic [NS-1:0]    s_req;
    logic [NS-1:0]    s_gnt;
    logic [AW-1:0]    s_addr;
    logic             s_we;
    logic [BW-1:0]    s_be;
    logic [DW-1:0]    s_wdata;
    logic [NS-1:0]    s_rvalid;
    logic [NS*DW-1:0] s_rdata;
    logic [7:0]       err_count;
    logic [AW-1:0]    last_err_addr;

    int n_assert = 0;
    int n_fail   = 0;
    int gnt_cnt;
    int rv_cnt;

    always #5 clk = ~clk;

    bus_addr_router #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BASE_ADDRS(BASES), .END_ADDRS(ENDS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_we(m_we), .m_be(m_be),
        .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_gnt(s_gnt), .s_addr(s_addr), .s_we(s_we), .s_be(s_be),
        .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .err_count(err_count), .last_err_addr(last_err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; checks happen 2 time units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdata(input int idx, input logic [DW-1:0] v);
        s_rdata[idx*DW +: DW] = v;
    endtask

    initial begin
        rst = 1'b1; m_req = 1'b0; m_addr = '0; m_we = 1'b0; m_be = '0; m_wdata = '0;
        s_gnt = '0; s_rvalid = '0; s_rdata = '0;
        tick(); tick();
        // Reset: outputs quiet even with a pending unmapped request.
        m_req = 1'b1; m_addr = 32'h0200_0000;
        #2;
        chk("rst_m_gnt", 64'(m_gnt), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_s_req", 64'(s_req), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_last_err", 64'(last_err_addr), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata), 64'd0);
        tick();
        rst = 1'b0; m_req = 1'b0;

        // UART read, slave responds 2 cycles after accept.
        tick();
        set_rdata(4, 32'hDEAD); set_rdata(5, 32'hA5);
        m_req = 1'b1; m_addr = 32'h0100_2004; m_we = 1'b0; s_gnt = 9'h020;
        #2;
        chk("uart_s_req", 64'(s_req), 64'h020);
        chk("uart_s_addr", 64'(s_addr), 64'h4);
        chk("uart_m_gnt", 64'(m_gnt), 64'd1);
        tick();
        m_req = 1'b0; s_gnt = '0;
        #2;
        chk("uart_c1_rvalid", 64'(m_rvalid), 64'd0);
        chk("uart_c1_s_req", 64'(s_req), 64'd0);
        tick();
        s_rvalid = 9'h020;
        #2;
        chk("uart_rvalid", 64'(m_rvalid), 64'd1);
        chk("uart_rdata", 64'(m_rdata), 64'hA5);
        chk("uart_err", 64'(m_err), 64'd0);
        chk("uart_gnt_with_rvalid", 64'(m_gnt), 64'd0);
        tick();
        s_rvalid = '0;
        #2;
        chk("uart_c3_rvalid", 64'(m_rvalid), 64'd0);

        // Unmapped write: granted immediately, error one cycle later, no slave request.
        tick();
        m_req = 1'b1; m_addr = 32'h0200_0000; m_we = 1'b1; s_gnt = '1;
        #2;
        chk("unm_m_gnt", 64'(m_gnt), 64'd1);
        chk("unm_s_req", 64'(s_req), 64'd0);
        tick();
        m_addr = 32'h0000_0010; m_we = 1'b0;
        #2;
        chk("unm_rvalid", 64'(m_rvalid), 64'd1);
        chk("unm_err", 64'(m_err), 64'd1);
        chk("unm_rdata", 64'(m_rdata), 64'd0);
        chk("unm_gnt_in_err", 64'(m_gnt), 64'd0);
        chk("unm_s_req_in_err", 64'(s_req), 64'd0);
        // Back-to-back accept to ROM in the cycle after the error response.
        tick();
        set_rdata(0, 32'h1234);
        #2;
        chk("b2b_m_gnt", 64'(m_gnt), 64'd1);
        chk("b2b_s_req", 64'(s_req), 64'h001);
        chk("b2b_s_addr", 64'(s_addr), 64'h10);
        chk("b2b_err_count", 64'(err_count), 64'd1);
        chk("b2b_last_err", 64'(last_err_addr), 64'h0200_0000);
        tick();
        m_req = 1'b0; s_gnt = '0; s_rvalid = 9'h021;
        #2;
        chk("b2b_rvalid", 64'(m_rvalid), 64'd1);
        chk("b2b_rdata", 64'(m_rdata), 64'h1234);
        tick();
        s_rvalid = '0;

        // GPIO write: broadcast fields, offset address.
        tick();
        m_req = 1'b1; m_addr = 32'h0100_1008; m_we = 1'b1; m_be = 4'b0011;
        m_wdata = 32'hCAFE_BABE; s_gnt = 9'h010;
        #2;
        chk("wr_s_req", 64'(s_req), 64'h010);
        chk("wr_s_addr", 64'(s_addr), 64'h8);
        chk("wr_s_we", 64'(s_we), 64'd1);
        chk("wr_s_be", 64'(s_be), 64'h3);
        chk("wr_s_wdata", 64'(s_wdata), 64'hCAFE_BABE);
        tick();
        m_req = 1'b0; s_gnt = '0; s_rvalid = 9'h010;
        #2;
        chk("wr_rvalid", 64'(m_rvalid), 64'd1);
        tick();
        s_rvalid = '0; m_we = 1'b0;

        // Timeout on SPI: error at cycle 5 after accept; foreign and late rvalids ignored.
        tick();
        m_req = 1'b1; m_addr = 32'h0100_3000; s_gnt = '1;
        #2;
        chk("tmo_s_req", 64'(s_req), 64'h040);
        tick();
        m_req = 1'b0; s_gnt = '0;
        for (int c = 1; c <= 4; c++) begin
            s_rvalid = (c == 2) ? 9'h080 : 9'h000;
            #2;
            chk($sformatf("tmo_c%0d_rvalid", c), 64'(m_rvalid), 64'd0);
            tick();
        end
        s_rvalid = '0;
        #2;
        chk("tmo_c5_rvalid", 64'(m_rvalid), 64'd1);
        chk("tmo_c5_err", 64'(m_err), 64'd1);
        chk("tmo_c5_rdata", 64'(m_rdata), 64'd0);
        tick();
        #2;
        chk("tmo_c6_rvalid", 64'(m_rvalid), 64'd0);
        chk("tmo_err_count", 64'(err_count), 64'd2);
        chk("tmo_last_err", 64'(last_err_addr), 64'h0100_3000);
        tick();
        s_rvalid = 9'h040;
        #2;
        chk("tmo_late_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        s_rvalid = '0;

        // Timer responds on the last allowed cycle: valid response wins over timeout.
        tick();
        set_rdata(7, 32'h77);
        m_req = 1'b1; m_addr = 32'h0100_4010; s_gnt = 9'h080;
        tick();
        m_req = 1'b0; s_gnt = '0;
        tick(); tick(); tick();
        s_rvalid = 9'h080;
        #2;
        chk("edge_rvalid", 64'(m_rvalid), 64'd1);
        chk("edge_err", 64'(m_err), 64'd0);
        chk("edge_rdata", 64'(m_rdata), 64'h77);
        tick();
        s_rvalid = '0;
        #2;
        chk("edge_c5_rvalid", 64'(m_rvalid), 64'd0);
        chk("edge_err_count", 64'(err_count), 64'd2);

        // Overlap 2/3 with grant withheld 3 cycles: only slave 2 requested, single accept.
        tick();
        set_rdata(2, 32'h22); set_rdata(3, 32'h33);
        m_req = 1'b1; m_addr = 32'h0100_0900; s_gnt = '0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("ovl_wait%0d_gnt", c), 64'(m_gnt), 64'd0);
            chk($sformatf("ovl_wait%0d_s_req", c), 64'(s_req), 64'h004);
            tick();
        end
        s_gnt = 9'h00C;
        #2;
        chk("ovl_s_addr", 64'(s_addr), 64'h900);
        chk("ovl_gnt", 64'(m_gnt), 64'd1);
        tick();
        m_req = 1'b0; s_gnt = '0;
        #2;
        chk("ovl_c1_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        s_rvalid = 9'h00C;
        #2;
        chk("ovl_rvalid", 64'(m_rvalid), 64'd1);
        chk("ovl_rdata", 64'(m_rdata), 64'h22);
        tick();
        #2;
        chk("ovl_single_rsp", 64'(m_rvalid), 64'd0);
        tick();
        s_rvalid = '0;

        // 300 unmapped accesses: counter saturates.
        gnt_cnt = 0;
        rv_cnt  = 0;
        for (int i = 0; i < 300; i++) begin
            m_req = 1'b1; m_addr = 32'h0300_0000 + 32'(i * 4);
            #2;
            if (m_gnt) gnt_cnt++;
            tick();
            #2;
            if (m_rvalid && m_err) rv_cnt++;
            tick();
        end
        m_req = 1'b0;
        #2;
        chk("sat_gnt_cnt", 64'(gnt_cnt), 64'd300);
        chk("sat_rsp_cnt", 64'(rv_cnt), 64'd300);
        chk("sat_err_count", 64'(err_count), 64'hFF);
        chk("sat_last_err", 64'(last_err_addr), 64'h0300_04AC);

        // Reset mid-transaction to PMC: pending response dropped, stats cleared.
        tick();
        m_req = 1'b1; m_addr = 32'h0100_5000; s_gnt = 9'h100;
        tick();
        m_req = 1'b0; s_gnt = '0;
        tick();
        rst = 1'b1; s_rvalid = 9'h100;
        #2;
        chk("mid_rst_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        rst = 1'b0;
        #2;
        chk("post_rst_rvalid", 64'(m_rvalid), 64'd0);
        chk("post_rst_err_count", 64'(err_count), 64'd0);
        chk("post_rst_last_err", 64'(last_err_addr), 64'd0);
        tick();
        s_rvalid = '0;
        m_req = 1'b1; m_addr = 32'h0100_5004; s_gnt = 9'h100;
        #2;
        chk("post_rst_idle_gnt", 64'(m_gnt), 64'd1);
        chk("post_rst_s_req", 64'(s_req), 64'h100);
        tick();
        m_req = 1'b0; s_gnt = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
